// File: rtl/path_metric_argmax_ctrl.sv
// rtl/path_metric_argmax_ctrl.sv - sequential signed arg-max over the Viterbi state-metric RAM
module path_metric_argmax_ctrl #(
    parameter int p_size      = 32,
    parameter int POS_num_bit = 4,
    parameter int N_STATES    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic                   rd_en,
    output logic [POS_num_bit-1:0] rd_addr,
    input  logic [p_size-1:0]      rd_data,
    output logic                   busy,
    output logic                   done,
    output logic [p_size-1:0]      best_metric,
    output logic [POS_num_bit-1:0] best_index
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [POS_num_bit-1:0] LAST_ADDR = POS_num_bit'(N_STATES - 1);

    state_t                 state;
    logic                   rd_vld;
    logic [POS_num_bit-1:0] data_idx;
    logic [p_size-1:0]      run_max;
    logic [POS_num_bit-1:0] run_idx;
    logic                   take;
    logic [p_size-1:0]      cand_max;
    logic [POS_num_bit-1:0] cand_idx;

    // Strict compare keeps the earlier index on ties; sample 0 always loads.
    always_comb begin
        take     = 1'b0;
        cand_max = run_max;
        cand_idx = run_idx;
        take     = (data_idx == '0) || ($signed(rd_data) > $signed(run_max));
        if (take) begin
            cand_max = rd_data;
            cand_idx = data_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            best_metric <= '0;
            best_index  <= '0;
            rd_vld      <= 1'b0;
            data_idx    <= '0;
            run_max     <= '0;
            run_idx     <= '0;
        end else begin
            done   <= 1'b0;
            rd_vld <= rd_en;
            if (rd_vld) begin
                run_max  <= cand_max;
                run_idx  <= cand_idx;
                data_idx <= data_idx + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state    <= READ;
                        rd_en    <= 1'b1;
                        rd_addr  <= '0;
                        busy     <= 1'b1;
                        data_idx <= '0;
                    end
                end
                READ: begin
                    if (abort) begin
                        state  <= IDLE;
                        rd_en  <= 1'b0;
                        busy   <= 1'b0;
                        rd_vld <= 1'b0;
                    end else if (rd_addr == LAST_ADDR) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // The final sample is still on rd_data; publish through the compare path.
                    state  <= IDLE;
                    busy   <= 1'b0;
                    rd_vld <= 1'b0;
                    if (!abort) begin
                        done        <= 1'b1;
                        best_metric <= cand_max;
                        best_index  <= cand_idx;
                    end
                end
                default: begin
                    state <= IDLE;
                    rd_en <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_metric_argmax_ctrl.sv
// tb/tb_path_metric_argmax_ctrl.sv - scoreboard bench for path_metric_argmax_ctrl
module tb_path_metric_argmax_ctrl;

    typedef struct packed {
        logic [31:0] m;
        logic [3:0]  i;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [31:0] best_metric;
    logic [3:0]  best_index;

    logic        start1 = 1'b0;
    logic        abort1 = 1'b0;
    logic        rd_en1;
    logic [3:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic        busy1;
    logic        done1;
    logic [31:0] best_metric1;
    logic [3:0]  best_index1;

    logic [31:0] mem [16];
    logic [31:0] mem1;
    res_t        exp_q [$];
    res_t        exp1_q [$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;

    always #5 clk = ~clk;

    path_metric_argmax_ctrl #(.p_size(32), .POS_num_bit(4), .N_STATES(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .best_metric(best_metric), .best_index(best_index)
    );

    path_metric_argmax_ctrl #(.p_size(32), .POS_num_bit(4), .N_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .busy(busy1), .done(done1), .best_metric(best_metric1), .best_index(best_index1)
    );

    // Metric RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (rd_en1 && rd_addr1 == 4'd0) rd_data1 <= mem1;
    end

    function automatic res_t model();
        res_t r;
        r.m = mem[0];
        r.i = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if ($signed(mem[k]) > $signed(r.m)) begin
                r.m = mem[k];
                r.i = 4'(k);
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle T+1; returns the cycle offset from T at which done is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        chk_cnt++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %0b expected 0", rd_en); else pass_cnt++;
        chk_cnt++; if (rd_addr !== 4'd0) $display("FAIL reset_rd_addr: got %0h expected 0", rd_addr); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else pass_cnt++;
        chk_cnt++; if (best_metric !== 32'd0) $display("FAIL reset_best_metric: got %0h expected 0", best_metric); else pass_cnt++;
        chk_cnt++; if (best_index !== 4'd0) $display("FAIL reset_best_index: got %0h expected 0", best_index); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ascending();
        res_t e;
        for (int k = 0; k < 16; k++) mem[k] = 32'(k);
        exp_q.push_back(model());
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_cnt++;
            if (rd_en !== 1'b1 || rd_addr !== 4'(k))
                $display("FAIL asc_sweep_%0d: got rd_en=%0b rd_addr=%0d expected 1/%0d", k, rd_en, rd_addr, k);
            else pass_cnt++;
            tick();
        end
        chk_cnt++;
        if (busy !== 1'b1 || done !== 1'b0 || rd_en !== 1'b0 || best_metric !== 32'd0)
            $display("FAIL asc_drain: got busy=%0b done=%0b rd_en=%0b best=%0h expected 1/0/0/0", busy, done, rd_en, best_metric);
        else pass_cnt++;
        tick();
        e = exp_q.pop_front();
        chk_cnt++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL asc_done: got done=%0b busy=%0b expected 1/0", done, busy); else pass_cnt++;
        chk_cnt++; if (best_metric !== e.m) $display("FAIL asc_metric: got %0h expected %0h", best_metric, e.m); else pass_cnt++;
        chk_cnt++; if (best_index !== e.i) $display("FAIL asc_index: got %0d expected %0d", best_index, e.i); else pass_cnt++;
        tick();
        chk_cnt++; if (done !== 1'b0) $display("FAIL asc_done_pulse: got %0b expected 0", done); else pass_cnt++;
    endtask

    task automatic test_neg_ties();
        int lat;
        res_t e;
        for (int k = 0; k < 16; k++) mem[k] = -32'sd5;
        mem[3] = -32'sd1;
        mem[9] = -32'sd1;
        exp_q.push_back(model());
        start = 1'b1; tick(); start = 1'b0;
        wait_done(lat);
        e = exp_q.pop_front();
        chk_cnt++; if (lat != 18) $display("FAIL neg_latency: got %0d expected 18", lat); else pass_cnt++;
        chk_cnt++; if (best_metric !== e.m || best_metric !== 32'hFFFF_FFFF) $display("FAIL neg_metric: got %0h expected %0h", best_metric, e.m); else pass_cnt++;
        chk_cnt++; if (best_index !== e.i || best_index !== 4'd3) $display("FAIL neg_index: got %0d expected %0d", best_index, e.i); else pass_cnt++;
        tick();
        for (int k = 0; k < 16; k++) mem[k] = 32'h8000_0000;
        exp_q.push_back(model());
        start = 1'b1; tick(); start = 1'b0;
        wait_done(lat);
        e = exp_q.pop_front();
        chk_cnt++; if (lat != 18) $display("FAIL min_latency: got %0d expected 18", lat); else pass_cnt++;
        chk_cnt++; if (best_metric !== e.m) $display("FAIL min_metric: got %0h expected %0h", best_metric, e.m); else pass_cnt++;
        chk_cnt++; if (best_index !== 4'd0) $display("FAIL min_index: got %0d expected 0", best_index); else pass_cnt++;
        tick();
    endtask

    task automatic test_ends();
        int lat;
        res_t e;
        for (int k = 0; k < 16; k++) mem[k] = 32'd99;
        mem[0] = 32'd100;
        exp_q.push_back(model());
        start = 1'b1; tick(); start = 1'b0;
        wait_done(lat);
        e = exp_q.pop_front();
        chk_cnt++; if (best_metric !== e.m || best_index !== 4'd0) $display("FAIL first_max: got %0h@%0d expected %0h@0", best_metric, best_index, e.m); else pass_cnt++;
        tick();
        for (int k = 0; k < 15; k++) mem[k] = $urandom & 32'hFFFF_FFFE;
        mem[15] = 32'h7FFF_FFFF;
        exp_q.push_back(model());
        start = 1'b1; tick(); start = 1'b0;
        wait_done(lat);
        e = exp_q.pop_front();
        chk_cnt++; if (lat != 18) $display("FAIL last_latency: got %0d expected 18", lat); else pass_cnt++;
        chk_cnt++; if (best_metric !== e.m || best_index !== 4'd15) $display("FAIL last_max: got %0h@%0d expected %0h@15", best_metric, best_index, e.m); else pass_cnt++;
        tick();
    endtask

    task automatic test_abort();
        int lat;
        bit seen;
        res_t e;
        for (int k = 0; k < 16; k++) mem[k] = 32'd1;
        mem[2] = 32'd7;
        exp_q.push_back(model());
        start = 1'b1; tick(); start = 1'b0;
        wait_done(lat);
        e = exp_q.pop_front();
        chk_cnt++; if (best_metric !== e.m || best_index !== e.i) $display("FAIL abort_pre: got %0h@%0d expected %0h@%0d", best_metric, best_index, e.m, e.i); else pass_cnt++;
        tick();
        for (int k = 0; k < 16; k++) mem[k] = 32'd1000 + 32'(k);
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_cnt++; if (rd_en !== 1'b0 || busy !== 1'b0) $display("FAIL abort_stop: got rd_en=%0b busy=%0b expected 0/0", rd_en, busy); else pass_cnt++;
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            seen |= (done === 1'b1) || (busy === 1'b1);
            tick();
        end
        chk_cnt++; if (seen) $display("FAIL abort_no_done: got activity=1 expected 0"); else pass_cnt++;
        chk_cnt++; if (best_metric !== 32'd7 || best_index !== 4'd2) $display("FAIL abort_hold: got %0h@%0d expected 7@2", best_metric, best_index); else pass_cnt++;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk_cnt++; if (busy !== 1'b0 || rd_en !== 1'b0) $display("FAIL abort_wins: got busy=%0b rd_en=%0b expected 0/0", busy, rd_en); else pass_cnt++;
        for (int k = 0; k < 16; k++) mem[k] = 32'(3 * k) - 32'd20;
        mem[6] = 32'd500;
        exp_q.push_back(model());
        start = 1'b1; tick(); start = 1'b0;
        wait_done(lat);
        e = exp_q.pop_front();
        chk_cnt++; if (lat != 18 || best_metric !== e.m || best_index !== e.i) $display("FAIL abort_recover: got %0h@%0d lat %0d expected %0h@%0d lat 18", best_metric, best_index, lat, e.m, e.i); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        res_t e;
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        exp_q.push_back(model());
        start = 1'b1;
        tick();
        wait_done(lat);
        e = exp_q.pop_front();
        chk_cnt++; if (lat != 18) $display("FAIL b2b_first_latency: got %0d expected 18", lat); else pass_cnt++;
        chk_cnt++; if (best_metric !== e.m || best_index !== e.i) $display("FAIL b2b_first: got %0h@%0d expected %0h@%0d", best_metric, best_index, e.m, e.i); else pass_cnt++;
        for (int k = 0; k < 16; k++) mem[k] = $urandom;
        exp_q.push_back(model());
        tick();
        start = 1'b0;
        chk_cnt++; if (rd_en !== 1'b1 || rd_addr !== 4'd0 || busy !== 1'b1) $display("FAIL b2b_restart: got rd_en=%0b addr=%0d busy=%0b expected 1/0/1", rd_en, rd_addr, busy); else pass_cnt++;
        wait_done(lat);
        e = exp_q.pop_front();
        chk_cnt++; if (lat != 18) $display("FAIL b2b_second_latency: got %0d expected 18", lat); else pass_cnt++;
        chk_cnt++; if (best_metric !== e.m || best_index !== e.i) $display("FAIL b2b_second: got %0h@%0d expected %0h@%0d", best_metric, best_index, e.m, e.i); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int k = 0; k < 16; k++) mem[k] = 32'd77;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_cnt++;
        if (rd_en !== 1'b0 || rd_addr !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || best_metric !== 32'd0 || best_index !== 4'd0)
            $display("FAIL mid_reset: got rd_en=%0b addr=%0d busy=%0b done=%0b best=%0h@%0d expected all 0",
                     rd_en, rd_addr, busy, done, best_metric, best_index);
        else pass_cnt++;
        seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            seen |= (done === 1'b1);
            tick();
        end
        chk_cnt++; if (seen) $display("FAIL mid_reset_no_done: got done=1 expected 0"); else pass_cnt++;
    endtask

    task automatic test_single();
        int lat;
        res_t e;
        mem1 = -32'sd42;
        e.m = -32'sd42;
        e.i = 4'd0;
        exp1_q.push_back(e);
        start1 = 1'b1; tick(); start1 = 1'b0;
        lat = 1;
        while (done1 !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        e = exp1_q.pop_front();
        chk_cnt++; if (lat != 3) $display("FAIL single_latency: got %0d expected 3", lat); else pass_cnt++;
        chk_cnt++; if (best_metric1 !== e.m || best_index1 !== e.i) $display("FAIL single_result: got %0h@%0d expected %0h@%0d", best_metric1, best_index1, e.m, e.i); else pass_cnt++;
        tick();
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = '0;
        mem1 = '0;
        test_reset();
        test_ascending();
        test_neg_ties();
        test_ends();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_single();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
